// File: rtl/rshift_iter_if.sv
// rshift_iter_if: request/result handshake bundle for the iterative right-shift sequencer
interface rshift_iter_if #(parameter int N = 32, parameter int S = 5);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [S-1:0] in_amt;
  logic         in_sgn;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_sticky;
  logic         busy;
  modport master (output in_valid, in_data, in_amt, in_sgn, out_ready,
                  input  in_ready, out_valid, out_data, out_sticky, busy);
  modport slave  (input  in_valid, in_data, in_amt, in_sgn, out_ready,
                  output in_ready, out_valid, out_data, out_sticky, busy);
endinterface

// File: rtl/rshift_iter_ctrl.sv
// rshift_iter_ctrl: multi-cycle sticky right shift reusing one narrow stage; RSHIFT_ITER_EARLY_EXIT_EN stops once data is saturated
module rshift_iter_ctrl #(
  parameter int N = 32,
  parameter int S = 5,
  parameter int STEP_BITS = 2
) (
  input logic clk,
  input logic reset,
  rshift_iter_if.slave bus
);
  localparam int MAX_STEP = 2**STEP_BITS - 1;
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [N-1:0] data, data_n, mask, out_data;
  logic [S-1:0] rem, rem_n, step;
  logic [2*N-1:0] ext;
  logic sgn, sticky, sticky_n, out_sticky, early, fin;
  // one stage: shift by at most MAX_STEP, collecting the bits that fall off bit 0
  always_comb begin
    step = (rem < S'(MAX_STEP)) ? rem : S'(MAX_STEP);
    ext = {{N{sgn}}, data} >> step;
    data_n = ext[N-1:0];
    mask = (N'(1) << step) - N'(1);
    rem_n = rem - step;
`ifdef RSHIFT_ITER_EARLY_EXIT_EN
    early = (data_n == {N{sgn}}) && (rem_n != '0);
`else
    early = 1'b0;
`endif
    sticky_n = sticky | (|(data & mask)) | (early & sgn);
    fin = (rem_n == '0) || early;
  end
  // sequencer; results are copied to the output registers only on completion
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      data <= '0;
      rem <= '0;
      sgn <= 1'b0;
      sticky <= 1'b0;
      out_data <= '0;
      out_sticky <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          data <= bus.in_data;
          rem <= bus.in_amt;
          sgn <= bus.in_sgn;
          sticky <= 1'b0;
          state <= (bus.in_amt == '0) ? DONE : SHIFT;
          if (bus.in_amt == '0) begin
            out_data <= bus.in_data;
            out_sticky <= 1'b0;
          end
        end
        SHIFT: begin
          data <= data_n;
          rem <= early ? '0 : rem_n;
          sticky <= sticky_n;
          if (fin) begin
            state <= DONE;
            out_data <= data_n;
            out_sticky <= sticky_n;
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.in_ready = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy = (state == SHIFT) || (state == DONE);
  assign bus.out_data = out_data;
  assign bus.out_sticky = out_sticky;
endmodule
